// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg
//   Shared definitions for the trap sequencer: bus widths, FSM state
//   encodings, mcause constants, mtvec mode encoding, the epc source select
//   and the trap-target helper used by the sequencer when entering a trap.
package trap_ctrl_pkg;

  localparam int DATA_BUS      = 64;
  localparam int INST_ADDR_BUS = 64;

  typedef enum logic [2:0] {
    TRAP_ST_IDLE     = 3'd0,
    TRAP_ST_DRAIN    = 3'd1,
    TRAP_ST_ENTER    = 3'd2,
    TRAP_ST_RETURN   = 3'd3,
    TRAP_ST_REDIRECT = 3'd4
  } trap_state_e;

  // Which commit PC becomes mepc: synchronous exceptions restart the
  // trapping instruction, interrupts resume after the committed one.
  typedef enum logic {
    EPC_SEL_PC  = 1'b0,
    EPC_SEL_NPC = 1'b1
  } epc_sel_e;

  localparam logic [DATA_BUS-1:0] TRAP_CAUSE_ECALL  = 64'd11;
  localparam logic [DATA_BUS-1:0] TRAP_CAUSE_EBREAK = 64'd3;
  localparam logic [DATA_BUS-1:0] TRAP_CAUSE_MTI    = 64'h8000_0000_0000_0007;

  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

  // Trap handler address. Only interrupts are vectored; exceptions always
  // land on the base address even when mtvec is in vectored mode.
  function automatic logic [INST_ADDR_BUS-1:0] trap_target(
    input logic [DATA_BUS-1:0] mtvec,
    input logic [DATA_BUS-1:0] cause
  );
    logic [INST_ADDR_BUS-1:0] base;
    base = {mtvec[63:2], 2'b00};
    if ((mtvec[1:0] == MTVEC_MODE_VECTORED) && cause[63]) begin
      return base + {56'd0, cause[5:0], 2'b00};
    end
    return base;
  endfunction

endpackage

// File: rtl/trap_ctrl_prio.sv
// trap_prio
//   Combinational priority encoder that decides whether the committing
//   instruction raises an event and which one.
//   Ports:
//     commit_valid/ecall/ebreak/mret  commit-stage instruction info
//     mstatus_mie, mie_mtie, clint_mtip  timer interrupt enable/pending
//     accept   an event is taken this cycle
//     is_mret  the event is an mret (otherwise a trap)
//     cause    mcause value for a trap
//     epc_sel  which commit PC becomes mepc
module trap_prio
  import trap_ctrl_pkg::*;
(
  input  logic                commit_valid,
  input  logic                commit_ecall,
  input  logic                commit_ebreak,
  input  logic                commit_mret,
  input  logic                mstatus_mie,
  input  logic                mie_mtie,
  input  logic                clint_mtip,
  output logic                accept,
  output logic                is_mret,
  output logic [DATA_BUS-1:0] cause,
  output epc_sel_e            epc_sel
);

  logic irq_pending;

  assign irq_pending = mstatus_mie & mie_mtie & clint_mtip;

  // Synchronous events outrank the interrupt, so an interrupt only rides
  // along with an ordinary commit and otherwise waits for a later one.
  always_comb begin
    accept  = 1'b0;
    is_mret = 1'b0;
    cause   = '0;
    epc_sel = EPC_SEL_PC;
    if (commit_valid) begin
      if (commit_ecall) begin
        accept = 1'b1;
        cause  = TRAP_CAUSE_ECALL;
      end else if (commit_ebreak) begin
        accept = 1'b1;
        cause  = TRAP_CAUSE_EBREAK;
      end else if (commit_mret) begin
        accept  = 1'b1;
        is_mret = 1'b1;
      end else if (irq_pending) begin
        accept  = 1'b1;
        cause   = TRAP_CAUSE_MTI;
        epc_sel = EPC_SEL_NPC;
      end
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl
//   Trap sequencer between commit and the machine-mode CSR file. Captures
//   ecall/ebreak/mret/timer interrupt at commit, flushes younger work,
//   waits for the pipeline to drain, strobes the CSR file once, then
//   redirects fetch over a valid/ready handshake.
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     commit_*            committing instruction info
//     mstatus_mie, mie_mtie, clint_mtip  interrupt enable/pending
//     mtvec, mepc         current CSR values
//     pipe_empty          nothing in flight in fetch/execute
//     redirect_ready      fetch accepts the redirect
//     flush, stall_req    pipeline control
//     trap_en, ret_en     one-cycle CSR strobes
//     trap_cause, trap_epc  values written on trap entry
//     redirect_valid, redirect_pc  fetch redirect request
//     busy                sequencer not idle
module trap_ctrl
  import trap_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     commit_valid,
  input  logic [INST_ADDR_BUS-1:0] commit_pc,
  input  logic [INST_ADDR_BUS-1:0] commit_npc,
  input  logic                     commit_ecall,
  input  logic                     commit_ebreak,
  input  logic                     commit_mret,
  input  logic                     mstatus_mie,
  input  logic                     mie_mtie,
  input  logic                     clint_mtip,
  input  logic [DATA_BUS-1:0]      mtvec,
  input  logic [DATA_BUS-1:0]      mepc,
  input  logic                     pipe_empty,
  input  logic                     redirect_ready,
  output logic                     flush,
  output logic                     stall_req,
  output logic                     trap_en,
  output logic                     ret_en,
  output logic [DATA_BUS-1:0]      trap_cause,
  output logic [DATA_BUS-1:0]      trap_epc,
  output logic                     redirect_valid,
  output logic [INST_ADDR_BUS-1:0] redirect_pc,
  output logic                     busy
);

  trap_state_e state, state_next;

  logic                     ev_accept;
  logic                     ev_is_mret;
  logic [DATA_BUS-1:0]      ev_cause;
  epc_sel_e                 ev_epc_sel;

  logic                     pend_is_mret;
  logic [DATA_BUS-1:0]      pend_cause;
  logic [INST_ADDR_BUS-1:0] pend_epc;

  logic capture;
  logic load_trap_vals;
  logic load_target;
  logic load_mepc;

  trap_prio u_prio (
    .commit_valid  (commit_valid),
    .commit_ecall  (commit_ecall),
    .commit_ebreak (commit_ebreak),
    .commit_mret   (commit_mret),
    .mstatus_mie   (mstatus_mie),
    .mie_mtie      (mie_mtie),
    .clint_mtip    (clint_mtip),
    .accept        (ev_accept),
    .is_mret       (ev_is_mret),
    .cause         (ev_cause),
    .epc_sel       (ev_epc_sel)
  );

  // State register and all datapath registers. Every output either comes
  // from here or decodes the state, so reset clears all of them at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= TRAP_ST_IDLE;
      flush        <= 1'b0;
      stall_req    <= 1'b0;
      pend_is_mret <= 1'b0;
      pend_cause   <= '0;
      pend_epc     <= '0;
      trap_cause   <= '0;
      trap_epc     <= '0;
      redirect_pc  <= '0;
    end else begin
      state     <= state_next;
      flush     <= capture;
      stall_req <= (state_next != TRAP_ST_IDLE);
      if (capture) begin
        pend_is_mret <= ev_is_mret;
        pend_cause   <= ev_cause;
        pend_epc     <= (ev_epc_sel == EPC_SEL_NPC) ? commit_npc : commit_pc;
      end
      // The CSR-facing cause/epc only change as ENTER begins, so they are
      // steady throughout the trap_en strobe and hold afterwards.
      if (load_trap_vals) begin
        trap_cause <= pend_cause;
        trap_epc   <= pend_epc;
      end
      if (load_target) begin
        redirect_pc <= trap_target(mtvec, pend_cause);
      end else if (load_mepc) begin
        redirect_pc <= mepc;
      end
    end
  end

  // Next-state logic and state-decoded outputs. Commits outside IDLE belong
  // to instructions that are being flushed and are deliberately ignored.
  always_comb begin
    state_next     = state;
    capture        = 1'b0;
    load_trap_vals = 1'b0;
    load_target    = 1'b0;
    load_mepc      = 1'b0;
    trap_en        = 1'b0;
    ret_en         = 1'b0;
    redirect_valid = 1'b0;
    busy           = (state != TRAP_ST_IDLE);
    unique case (state)
      TRAP_ST_IDLE: begin
        if (ev_accept) begin
          capture    = 1'b1;
          state_next = TRAP_ST_DRAIN;
        end
      end
      TRAP_ST_DRAIN: begin
        if (pipe_empty) begin
          if (pend_is_mret) begin
            state_next = TRAP_ST_RETURN;
          end else begin
            load_trap_vals = 1'b1;
            state_next     = TRAP_ST_ENTER;
          end
        end
      end
      TRAP_ST_ENTER: begin
        trap_en     = 1'b1;
        load_target = 1'b1;
        state_next  = TRAP_ST_REDIRECT;
      end
      TRAP_ST_RETURN: begin
        ret_en     = 1'b1;
        load_mepc  = 1'b1;
        state_next = TRAP_ST_REDIRECT;
      end
      TRAP_ST_REDIRECT: begin
        redirect_valid = 1'b1;
        if (redirect_ready) begin
          state_next = TRAP_ST_IDLE;
        end
      end
      default: begin
        state_next = TRAP_ST_IDLE;
      end
    endcase
  end

endmodule
